// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code: the encoder
// FSM state encoding, default generators and the parity helper that both the
// encoder and the decoder branch-metric unit use to form code symbols.
package conv_pkg;

    localparam int K = 3;

    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL0 = 2'd2,
        ST_TAIL1 = 2'd3
    } conv_state_e;

    // Parity of generator taps over {u, sr[1], sr[0]}; bit2 of g taps u.
    function automatic logic conv_parity(input logic [2:0] g,
                                         input logic       u,
                                         input logic [1:0] sr);
        return ^(g & {u, sr});
    endfunction

endpackage

// File: rtl/conv_out_reg.sv
// One-entry valid/ready output register carrying a 2-bit symbol and a
// frame-last flag. It can drain and refill in the same cycle, so a producer
// that loads whenever slot_free is high sustains one symbol per clock.
module conv_out_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] load_sym,
    input  logic       load_last,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       slot_free,
    output logic       done
);

    logic       valid_q, valid_d;
    logic [1:0] sym_q, sym_d;
    logic       last_q, last_d;
    logic       done_q, done_d;

    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_sym   = sym_q;
    assign out_last  = last_q;
    assign done      = done_q;

    // Next-state: load wins over drain; held contents stay put while stalled.
    always_comb begin
        valid_d = valid_q;
        sym_d   = sym_q;
        last_d  = last_q;
        done_d  = valid_q && out_ready && last_q;
        if (load) begin
            valid_d = 1'b1;
            sym_d   = load_sym;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Register update with synchronous reset clearing the whole entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            sym_q   <= 2'b00;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail termination. Accepts
// FRAME_LEN info bits, appends two zero tail bits so the trellis returns to
// state 00, and emits one 2-bit symbol per bit through a backpressured
// output register.
module conv_encoder_k3
    import conv_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter logic [2:0] G0        = G0_DEF,
    parameter logic [2:0] G1        = G1_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    conv_state_e      state_q, state_d;
    logic [1:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       slot_free;
    logic       load;
    logic       load_u;
    logic       load_last;
    logic [1:0] load_sym;

    // FSM next-state, shift-register update and output-register load control.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_u    = 1'b0;
        load_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = 2'b00;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load   = 1'b1;
                    load_u = in_bit;
                    sr_d   = {in_bit, sr_q[1]};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(FRAME_LEN)) begin
                        state_d = ST_TAIL0;
                    end
                end
            end
            ST_TAIL0: begin
                if (slot_free) begin
                    load    = 1'b1;
                    sr_d    = {1'b0, sr_q[1]};
                    state_d = ST_TAIL1;
                end
            end
            ST_TAIL1: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    sr_d      = {1'b0, sr_q[1]};
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Code symbol for the bit being encoded, formed against the current state.
    always_comb begin
        load_sym = {conv_parity(G0, load_u, sr_q), conv_parity(G1, load_u, sr_q)};
    end

    // State, trellis shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    conv_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_sym  (load_sym),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .slot_free (slot_free),
        .done      (done)
    );

    assign busy = (state_q != ST_IDLE) || out_valid;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed bench for conv_encoder_k3: table of 4-bit frames with
// hand-computed symbol sequences, streamed under several backpressure
// patterns, plus hand-written reset and FRAME_LEN=1 sequences.
module tb_conv_encoder_k3;
    import conv_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_bit, out_ready;
    logic       in_ready, out_valid, out_last, busy, done;
    logic [1:0] out_sym;

    logic       start2, in_valid2, in_bit2, out_ready2;
    logic       in_ready2, out_valid2, out_last2, busy2, done2;
    logic [1:0] out_sym2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_encoder_k3 #(.FRAME_LEN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_sym(out_sym), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    conv_encoder_k3 #(.FRAME_LEN(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_bit(in_bit2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_sym(out_sym2), .out_last(out_last2),
        .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    // bits[3] is the first bit sent; syms[11:10] is the first symbol.
    typedef struct {
        logic [3:0]  bits;
        logic [11:0] syms;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream nrows table frames back to back; mode 0: out_ready=1,
    // mode 1: out_ready pattern 1,0,0 repeating. noise pulses start mid-frame.
    task automatic run_frames(input int first, input int nrows, input int mode, input bit noise);
        int total_sym, total_bits, bi, got, fstarted, done_cnt, first_in_cyc, cyc;
        logic [1:0]  gsym[32];
        logic        glast[32];
        int          gcyc[32];
        logic        prev_stall, prev_last;
        logic [1:0]  prev_sym, e;
        logic [3:0]  b;
        logic [11:0] s;
        total_sym = nrows * 6;
        total_bits = nrows * 4;
        bi = 0; got = 0; fstarted = 0; done_cnt = 0; first_in_cyc = -1; cyc = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_sym = 2'b00;
        while (got < total_sym && cyc < 300) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            start = ((dut.state_q == ST_IDLE) && (fstarted < nrows)) ||
                    (noise && (dut.state_q != ST_IDLE) && (cyc % 2 == 0));
            if (dut.state_q == ST_IDLE && start) fstarted++;
            in_valid = (bi < total_bits);
            if (in_valid) begin
                b = tbl[first + bi / 4].bits;
                in_bit = b[3 - bi % 4];
            end else begin
                in_bit = 1'b0;
            end
            #1;
            if (prev_stall)
                check("hold_stable", {out_valid, out_last, out_sym}, {1'b1, prev_last, prev_sym});
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (dut.state_q == ST_TAIL0 || dut.state_q == ST_TAIL1)
                check("tail_in_ready", in_ready, 0);
            if (done) done_cnt++;
            if (in_valid && in_ready) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                bi++;
            end
            if (out_valid && out_ready) begin
                gsym[got] = out_sym;
                glast[got] = out_last;
                gcyc[got] = cyc;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sym = out_sym;
            prev_last = out_last;
            tick();
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("symbol_count", got, total_sym);
        if (done) done_cnt++;
        check("done_pulses", done_cnt, nrows);
        for (int k = 0; k < got; k++) begin
            s = tbl[first + k / 6].syms;
            e = s[11 - 2 * (k % 6) -: 2];
            check("sym", gsym[k], e);
            check("last_flag", glast[k], (k % 6 == 5) ? 1 : 0);
        end
        if (mode == 0 && nrows == 1 && got == total_sym)
            check("throughput", gcyc[total_sym - 1] - first_in_cyc, 6);
        check("busy_after", busy, 0);
        check("sr_after", dut.sr_q, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int c, got2;
        logic [1:0] s2[3];
        logic       l2[3];

        tbl[0] = '{bits: 4'b1011, syms: 12'b11_10_00_01_01_11};
        tbl[1] = '{bits: 4'b0000, syms: 12'b00_00_00_00_00_00};
        tbl[2] = '{bits: 4'b1111, syms: 12'b11_01_10_10_01_11};
        tbl[3] = '{bits: 4'b0100, syms: 12'b00_11_10_11_00_00};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; in_bit2 = 1'b0; out_ready2 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_out_sym", out_sym, 0);

        // Basic frame, free-flowing sink
        run_frames(0, 1, 0, 1'b0);
        // Same frame under toggling backpressure
        run_frames(0, 1, 1, 1'b0);
        // All-ones frame, in_valid held, throughput
        run_frames(2, 1, 0, 1'b0);

        // Reset after the second accepted bit
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        tick();
        in_bit = 1'b0;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", dut.state_q, ST_IDLE);
        check("midrst_sr", dut.sr_q, 0);
        check("midrst_out_last", out_last, 0);
        run_frames(0, 1, 0, 1'b0);

        // Back-to-back frames with stray start pulses
        run_frames(0, 4, 0, 1'b1);
        run_frames(1, 3, 1, 1'b1);

        // FRAME_LEN=1, bit 1
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        in_valid2 = 1'b1;
        in_bit2 = 1'b1;
        got2 = 0;
        c = 0;
        while (got2 < 3 && c < 20) begin
            #1;
            if (out_valid2 && out_ready2) begin
                s2[got2] = out_sym2;
                l2[got2] = out_last2;
                got2++;
            end
            tick();
            in_valid2 = 1'b0;
            c++;
        end
        check("fl1_count", got2, 3);
        if (got2 == 3) begin
            check("fl1_sym0", s2[0], 3);
            check("fl1_sym1", s2[1], 2);
            check("fl1_sym2", s2[2], 3);
            check("fl1_last", {l2[0], l2[1], l2[2]}, 1);
        end
        check("fl1_done", done2, 1);
        check("fl1_sr", dut2.sr_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
